// File: rtl/display_scan_scheduler.sv
// Scan controller for a 4-digit 7-segment display: digit multiplexing, brightness PWM,
// leading-zero blanking, per-digit blink and a frame-aligned valid/ready frame load.
module display_scan_scheduler #(
  parameter int SUB_DIV      = 1250,
  parameter int BLINK_FRAMES = 625
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [2:0]  brightness,
  input  logic        lz_en,
  input  logic [3:0]  blink_en,
  output logic [3:0]  cur_bcd,
  output logic [3:0]  digit_sel,
  output logic        dp_on,
  output logic        frame_start
);

  localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [2:0]       phase_q, phase_d;
  logic [1:0]       idx_q, idx_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;
  logic [15:0]      active_bcd_q, active_bcd_d;
  logic [3:0]       active_dp_q, active_dp_d;
  logic [15:0]      shadow_bcd_q, shadow_bcd_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic             pending_q, pending_d;
  logic             rdy_q, rdy_d;

  logic sub_wrap, phase_wrap, lfc, accept;
  logic [3:0] upper_zero;
  logic lzb, en;

  // Shadow/active double buffer: only the last frame cycle may swap, so frames never tear.
  always_comb begin
    sub_wrap   = (sub_cnt_q == SUB_LAST);
    phase_wrap = sub_wrap && (phase_q == 3'd7);
    lfc        = phase_wrap && (idx_q == 2'd3);
    accept     = load_valid && rdy_q && !pending_q;

    sub_cnt_d    = sub_wrap ? '0 : sub_cnt_q + 1'b1;
    phase_d      = sub_wrap ? phase_q + 3'd1 : phase_q;
    idx_d        = phase_wrap ? idx_q + 2'd1 : idx_q;
    blink_cnt_d  = blink_cnt_q;
    blink_ph_d   = blink_ph_q;
    active_bcd_d = active_bcd_q;
    active_dp_d  = active_dp_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    rdy_d        = 1'b1;

    if (accept) begin
      shadow_bcd_d = bcd_in;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    if (lfc) begin
      if (pending_q) begin
        active_bcd_d = shadow_bcd_q;
        active_dp_d  = shadow_dp_q;
        pending_d    = 1'b0;
      end
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = !blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt_q    <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      active_bcd_q <= '0;
      active_dp_q  <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      sub_cnt_q    <= sub_cnt_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      active_bcd_q <= active_bcd_d;
      active_dp_q  <= active_dp_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      rdy_q        <= rdy_d;
    end
  end

  // upper_zero[i] is set when digits i..3 are all zero; digit 0 is never blanked as a leading zero.
  always_comb begin
    upper_zero[3] = (active_bcd_q[15:12] == 4'd0);
    upper_zero[2] = upper_zero[3] && (active_bcd_q[11:8] == 4'd0);
    upper_zero[1] = upper_zero[2] && (active_bcd_q[7:4] == 4'd0);
    upper_zero[0] = upper_zero[1] && (active_bcd_q[3:0] == 4'd0);
    lzb = lz_en && (idx_q != 2'd0) && upper_zero[idx_q];
    en  = (phase_q <= brightness) && !lzb && !(blink_en[idx_q] && blink_ph_q);

    cur_bcd     = 4'd0;
    digit_sel   = 4'd0;
    dp_on       = 1'b0;
    frame_start = 1'b0;
    load_ready  = 1'b0;
    if (!rst) begin
      cur_bcd     = active_bcd_q[{idx_q, 2'b00} +: 4];
      digit_sel   = en ? (4'd1 << idx_q) : 4'd0;
      dp_on       = en && active_dp_q[idx_q];
      frame_start = (idx_q == 2'd0) && (phase_q == 3'd0) && (sub_cnt_q == '0);
      load_ready  = rdy_q && !pending_q;
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Scoreboard bench for display_scan_scheduler: directed stimulus pushes hand-computed
// per-cycle expectations; a negedge monitor pops and compares them.
module tb_display_scan_scheduler;

  localparam int SUB_DIV      = 2;
  localparam int BLINK_FRAMES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [2:0]  brightness = 3'd7;
  logic        lz_en = 1'b0;
  logic [3:0]  blink_en = '0;
  logic [3:0]  cur_bcd;
  logic [3:0]  digit_sel;
  logic        dp_on;
  logic        frame_start;

  display_scan_scheduler #(.SUB_DIV(SUB_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load_valid(load_valid),
    .load_ready(load_ready), .brightness(brightness), .lz_en(lz_en), .blink_en(blink_en),
    .cur_bcd(cur_bcd), .digit_sel(digit_sel), .dp_on(dp_on), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int abs_cyc = 0;
  always @(posedge clk) abs_cyc <= abs_cyc + 1;

  // mask bits: 0 digit_sel, 1 cur_bcd, 2 dp_on, 3 frame_start, 4 load_ready
  typedef struct {
    int         cyc;
    logic [4:0] mask;
    logic [3:0] sel;
    logic [3:0] bcd;
    logic       dp;
    logic       fs;
    logic       rdy;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   base = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic push_exp(input int rel, input logic [4:0] mask, input logic [3:0] sel,
                          input logic [3:0] bcd, input logic dp, input logic fs,
                          input logic rdy, input string name);
    exp_t e;
    e.cyc = base + rel; e.mask = mask; e.sel = sel; e.bcd = bcd;
    e.dp = dp; e.fs = fs; e.rdy = rdy; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input string field, input int cyc,
                             input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s.%s at abs cycle %0d: got %b, required %b", name, field, cyc, act, req);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] b, input logic [3:0] d);
    load_valid = v;
    bcd_in     = b;
    dp_in      = d;
  endtask

  task automatic wait_to(input int rel);
    while (abs_cyc < base + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds rst for two cycles, checking the reset-value outputs on the first, then releases.
  task automatic do_reset(input string name);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    base = abs_cyc;
    push_exp(0, 5'b11111, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, name);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst  = 1'b0;
    base = abs_cyc;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < abs_cyc) begin
      e = sb_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s missed at abs cycle %0d (now %0d)", e.name, e.cyc, abs_cyc);
    end
    while (sb_q.size() > 0 && sb_q[0].cyc == abs_cyc) begin
      e = sb_q.pop_front();
      if (e.mask[0]) checkOutput(e.name, "digit_sel", e.cyc, digit_sel, e.sel);
      if (e.mask[1]) checkOutput(e.name, "cur_bcd", e.cyc, cur_bcd, e.bcd);
      if (e.mask[2]) checkOutput(e.name, "dp_on", e.cyc, {3'b000, dp_on}, {3'b000, e.dp});
      if (e.mask[3]) checkOutput(e.name, "frame_start", e.cyc, {3'b000, frame_start}, {3'b000, e.fs});
      if (e.mask[4]) checkOutput(e.name, "load_ready", e.cyc, {3'b000, load_ready}, {3'b000, e.rdy});
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Scan order, frame-aligned load and back-pressure
    brightness = 3'd7; lz_en = 1'b0; blink_en = 4'b0000;
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    do_reset("reset_a");
    push_exp(0,   5'b01111, 4'b0001, 4'd0, 1'b0, 1'b1, 1'b0, "scan_c0");
    push_exp(1,   5'b01001, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, "scan_c1");
    push_exp(10,  5'b10001, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b1, "ready_c10");
    push_exp(11,  5'b10000, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "busy_c11");
    push_exp(15,  5'b00011, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, "scan_c15");
    push_exp(16,  5'b00011, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, "scan_c16");
    push_exp(31,  5'b00001, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, "scan_c31");
    push_exp(32,  5'b00001, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b0, "scan_c32");
    push_exp(40,  5'b00111, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b0, "hold_c40");
    push_exp(47,  5'b00001, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b0, "scan_c47");
    push_exp(48,  5'b00001, 4'b1000, 4'd0, 1'b0, 1'b0, 1'b0, "scan_c48");
    push_exp(63,  5'b11011, 4'b1000, 4'd0, 1'b0, 1'b0, 1'b0, "lfc_c63");
    push_exp(64,  5'b11111, 4'b0001, 4'd4, 1'b0, 1'b1, 1'b1, "commit_c64");
    push_exp(65,  5'b10010, 4'b0000, 4'd4, 1'b0, 1'b0, 1'b0, "accept2_c65");
    push_exp(80,  5'b00111, 4'b0010, 4'd3, 1'b0, 1'b0, 1'b0, "slot1_c80");
    push_exp(100, 5'b00111, 4'b0100, 4'd2, 1'b1, 1'b0, 1'b0, "slot2dp_c100");
    push_exp(112, 5'b00111, 4'b1000, 4'd1, 1'b0, 1'b0, 1'b0, "slot3_c112");
    push_exp(127, 5'b10110, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b0, "noskip_c127");
    push_exp(128, 5'b11111, 4'b0001, 4'd8, 1'b1, 1'b1, 1'b1, "commit2_c128");
    push_exp(144, 5'b00110, 4'b0000, 4'd7, 1'b0, 1'b0, 1'b0, "w2_c144");
    push_exp(160, 5'b00010, 4'b0000, 4'd6, 1'b0, 1'b0, 1'b0, "w2_c160");
    push_exp(176, 5'b00011, 4'b1000, 4'd5, 1'b0, 1'b0, 1'b0, "w2_c176");
    wait_to(10); applyStimulus(1'b1, 16'h1234, 4'b0100);
    wait_to(11); applyStimulus(1'b1, 16'h5678, 4'b0001);
    wait_to(65); applyStimulus(1'b0, 16'h0000, 4'b0000);
    wait_to(180);

    // Brightness PWM, changed live mid-frame
    brightness = 3'd2;
    do_reset("reset_b");
    push_exp(0,  5'b01001, 4'b0001, 4'd0, 1'b0, 1'b1, 1'b0, "pwm_c0");
    push_exp(5,  5'b00001, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, "pwm_c5");
    push_exp(6,  5'b00001, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "pwm_c6");
    push_exp(15, 5'b00001, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "pwm_c15");
    push_exp(16, 5'b00001, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, "pwm_c16");
    push_exp(21, 5'b00001, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, "pwm_c21");
    push_exp(22, 5'b00001, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "pwm_c22");
    push_exp(32, 5'b00001, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b0, "pwm0_c32");
    push_exp(33, 5'b00001, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b0, "pwm0_c33");
    push_exp(34, 5'b00001, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "pwm0_c34");
    push_exp(48, 5'b00001, 4'b1000, 4'd0, 1'b0, 1'b0, 1'b0, "pwm0_c48");
    push_exp(50, 5'b00001, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "pwm0_c50");
    wait_to(32); brightness = 3'd0;
    wait_to(52);

    // Leading-zero blanking
    brightness = 3'd7; lz_en = 1'b1;
    do_reset("reset_c");
    push_exp(0,   5'b01011, 4'b0001, 4'd0, 1'b0, 1'b1, 1'b0, "lz0_c0");
    push_exp(5,   5'b00001, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, "lz0_c5");
    push_exp(20,  5'b00001, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "lz0_c20");
    push_exp(40,  5'b00001, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "lz0_c40");
    push_exp(50,  5'b00001, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "lz0_c50");
    push_exp(64,  5'b00011, 4'b0001, 4'd5, 1'b0, 1'b0, 1'b0, "lz45_c64");
    push_exp(80,  5'b00011, 4'b0010, 4'd4, 1'b0, 1'b0, 1'b0, "lz45_c80");
    push_exp(96,  5'b00011, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "lz45_c96");
    push_exp(112, 5'b00001, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "lz45_c112");
    push_exp(128, 5'b00011, 4'b0001, 4'd5, 1'b0, 1'b0, 1'b0, "lz405_c128");
    push_exp(144, 5'b00011, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, "lz405_c144");
    push_exp(160, 5'b00011, 4'b0100, 4'd4, 1'b0, 1'b0, 1'b0, "lz405_c160");
    push_exp(176, 5'b00011, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "lz405_c176");
    wait_to(2);  applyStimulus(1'b1, 16'h0045, 4'b0000);
    wait_to(3);  applyStimulus(1'b0, 16'h0000, 4'b0000);
    wait_to(70); applyStimulus(1'b1, 16'h0405, 4'b0000);
    wait_to(71); applyStimulus(1'b0, 16'h0000, 4'b0000);
    wait_to(180);

    // Blink on digit 1, then reset with a frame still pending
    lz_en = 1'b0; blink_en = 4'b0010;
    do_reset("reset_d");
    push_exp(16,  5'b00001, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, "blink_c16");
    push_exp(80,  5'b00001, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, "blink_c80");
    push_exp(127, 5'b01001, 4'b1000, 4'd0, 1'b0, 1'b0, 1'b0, "blink_c127");
    push_exp(128, 5'b01001, 4'b0001, 4'd0, 1'b0, 1'b1, 1'b0, "blink_c128");
    push_exp(144, 5'b00001, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "blink_c144");
    push_exp(160, 5'b00001, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b0, "blink_c160");
    push_exp(176, 5'b00001, 4'b1000, 4'd0, 1'b0, 1'b0, 1'b0, "blink_c176");
    push_exp(195, 5'b10000, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1, "pend_c195");
    push_exp(196, 5'b10000, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "pend_c196");
    push_exp(199, 5'b00111, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, "pend_c199");
    push_exp(200, 5'b11111, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "rst_c200");
    push_exp(201, 5'b11111, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, "rst_c201");
    wait_to(195); applyStimulus(1'b1, 16'h9876, 4'b1111);
    wait_to(196); applyStimulus(1'b0, 16'h0000, 4'b0000);
    wait_to(200); rst = 1'b1;
    wait_to(202); rst = 1'b0; base = abs_cyc;
    push_exp(0,   5'b01111, 4'b0001, 4'd0, 1'b0, 1'b1, 1'b0, "post_c0");
    push_exp(16,  5'b00111, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, "post_c16");
    push_exp(64,  5'b11111, 4'b0001, 4'd0, 1'b0, 1'b1, 1'b1, "post_c64");
    push_exp(80,  5'b00111, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, "post_c80");
    push_exp(100, 5'b00111, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b0, "post_c100");
    push_exp(112, 5'b00111, 4'b1000, 4'd0, 1'b0, 1'b0, 1'b0, "post_c112");
    wait_to(120);

    repeat (3) @(posedge clk);
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s never checked (cycle %0d)", e.name, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
